uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures each completed character (9-bit data plus 3-bit error tag) and returns `fifo_full` to the receiver for overrun detection. It presents first-word-fall-through data to the register/bus interface, plus trigger-level and error-pending indications. With FIFO mode off it acts as a single holding register.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥4.
- DATA_W, 9, character width; 5–8-bit characters arrive zero-extended.
- ERR_W, 3, error tag width: [2]=frame, [1]=parity, [0]=overrun.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous, active-low reset.
- fifo_en  in  1  1 = DEPTH entries, 0 = effective depth 1.
- flush  in  1  discard all contents.
- wr_valid  in  1  one-cycle pulse when a character completes.
- wr_data  in  DATA_W  received character.
- wr_err  in  ERR_W  error tag for that character.
- rd_en  in  1  pop head entry.
- trig_sel  in  2  trigger level select.
- timeout_cycles  in  20  idle timeout in clk cycles; used only with the optional feature.
- rd_data  out  DATA_W  head entry data, valid while !empty.
- rd_err  out  ERR_W  head entry error tag.
- empty  out  1  no entries.
- fifo_full  out  1  count == effective depth.
- count  out  $clog2(DEPTH)+1  current occupancy.
- trig_irq  out  1  count ≥ trigger threshold.
- err_pending  out  1  at least one stored entry has a nonzero error tag.
- overrun_sticky  out  1  a write was dropped; held until flush.
- timeout_irq  out  1  character timeout (optional feature).

Behaviour:
- Reset: all outputs 0 except empty=1; pointers, count, error counter and timeout counter cleared; memory contents don't-care.
- Effective depth: DEPTH when fifo_en=1, else 1.
- Any change of fifo_en (edge detected on a registered copy) performs an automatic flush in the following cycle.
- Write:
  - Accepted on wr_valid when !fifo_full, or when fifo_full && rd_en && !empty in the same cycle.
  - Otherwise the entry is dropped and overrun_sticky is set.
  - Stored tag = wr_err.
- Read: rd_en with empty=1 is ignored. rd_en with !empty advances the read pointer.
- Output timing:
  - rd_data/rd_err are show-ahead: the head entry is visible without rd_en.
  - Latency from write to visibility is 1 cycle (empty falls the cycle after wr_valid).
- Status registers: count, empty, fifo_full, trig_irq and err_pending are all registered and updated in the same cycle as the pointers.
- Simultaneous read and write, non-empty: count unchanged, both pointers advance.
- Simultaneous read and write, empty: only the write takes effect.
- Pointers wrap modulo DEPTH; count saturates by construction at DEPTH.
- Flush:
  - Highest priority.
  - Clears pointers, count, error counter, overrun_sticky and timeout state.
  - A concurrent wr_valid or rd_en is discarded.
- Trigger thresholds: 00→1, 01→DEPTH/4, 10→DEPTH/2, 11→DEPTH-2. When fifo_en=0 the threshold is forced to 1.
- err_pending:
  - An internal counter increments on an accepted write with nonzero tag.
  - It decrements on a pop of a nonzero-tagged head.
  - Both in the same cycle: counter unchanged.
  - err_pending = (counter != 0).
- Reset mid-character: contents lost; no special recovery required.

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- Defined:
  - A 20-bit idle counter clears on any accepted write, read or flush, and increments while !empty.
  - When it equals timeout_cycles (timeout_cycles ≠ 0), timeout_irq is set.
  - timeout_irq clears on the next read, write or flush.
  - The counter holds at its value while timeout_irq=1.
- Undefined: no counter is built, timeout_irq is tied 0 and timeout_cycles is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W/ERR_W defaults.
  - Error bit index constants: ERR_FRAME=2, ERR_PARITY=1, ERR_OVERRUN=0.
  - Trigger-level encoding constants.
- Sub-module uart_fifo_mem: DEPTH×(DATA_W+ERR_W) register array with synchronous write and asynchronous read. It is reusable for the TX FIFO.

Test Plan:
- Fill, no reads: fifo_en=1, 16 writes → fifo_full=1, count=16. 17th write dropped, overrun_sticky=1. Pops return entries 0..15 in order.
- Simultaneous ops: full with rd_en+wr_valid in the same cycle → write accepted, count stays 16, no overrun. Empty with both → count=1 and rd_data = the new entry.
- Non-FIFO mode: fifo_en=0, write 0x155 then write 0x0AA without a read → fifo_full=1 after the first. Second dropped. rd_data=0x155, overrun_sticky=1.
- Error tracking and trigger: write tags 3'b100, 000, 010 with trig_sel=01 (threshold 4) → err_pending=1, trig_irq=0. Two pops → err_pending=1. Third pop → err_pending=0. A 4th write raises trig_irq.
- Flush and mode change: flush asserted together with wr_valid → count=0, empty=1, overrun_sticky=0, write discarded. Toggling fifo_en with 5 entries → empty=1 two cycles later.
- Timeout (macro defined): timeout_cycles=100, one write then idle → timeout_irq rises exactly 100 cycles after the write and falls the cycle after rd_en.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default character/tag widths, error tag bit
// positions and the receive trigger-level encoding with its threshold helper.
package uart_pkg;

    localparam int UART_DATA_W = 9;
    localparam int UART_ERR_W  = 3;

    // Bit positions inside the per-character error tag.
    localparam int ERR_FRAME   = 2;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 0;

    typedef enum logic [1:0] {
        TRIG_ONE       = 2'b00,
        TRIG_QUARTER   = 2'b01,
        TRIG_HALF      = 2'b10,
        TRIG_NEAR_FULL = 2'b11
    } trig_level_e;

    // Occupancy at which the receive trigger fires for a given select code.
    function automatic int trig_threshold(input logic [1:0] sel, input int depth);
        int result;
        case (trig_level_e'(sel))
            TRIG_ONE:     result = 1;
            TRIG_QUARTER: result = depth / 4;
            TRIG_HALF:    result = depth / 2;
            default:      result = depth - 2;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Generic FIFO storage: DEPTH x WIDTH register array, synchronous write,
// asynchronous (combinational) read so the head word is always visible.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    // Store the incoming word at the write address; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO of {data, error tag}
// with registered status (count/empty/full/trigger/error-pending), sticky
// overrun and single-register mode when fifo_en=0.
// Optional character idle timeout is built when UART_RX_FIFO_TIMEOUT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W,
    parameter int ERR_W  = UART_ERR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_en,
    input  logic                   flush,
    input  logic                   wr_valid,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ERR_W-1:0]       wr_err,
    input  logic                   rd_en,
    input  logic [1:0]             trig_sel,
    input  logic [19:0]            timeout_cycles,
    output logic [DATA_W-1:0]      rd_data,
    output logic [ERR_W-1:0]       rd_err,
    output logic                   empty,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   trig_irq,
    output logic                   err_pending,
    output logic                   overrun_sticky,
    output logic                   timeout_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = DATA_W + ERR_W;

    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [CW-1:0] err_cnt_reg, err_cnt_next;
    logic [CW-1:0] eff_depth, thresh;
    logic          empty_reg, full_reg, trig_reg, err_pend_reg, overrun_reg;
    logic          fifo_en_reg, auto_flush_reg;
    logic          flush_all, wr_ok, rd_ok, err_inc, err_dec;
    logic [WW-1:0] mem_rdata;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_reg),
        .wr_data ({wr_data, wr_err}),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rdata)
    );

    // Accept/pop decisions and next occupancy; flush (explicit or after a mode change) wins.
    always_comb begin
        flush_all    = flush || auto_flush_reg;
        rd_ok        = rd_en && !empty_reg && !flush_all;
        wr_ok        = wr_valid && !flush_all && (!full_reg || (rd_en && !empty_reg));
        eff_depth    = fifo_en ? CW'(DEPTH) : CW'(1);
        thresh       = fifo_en ? CW'(trig_threshold(trig_sel, DEPTH)) : CW'(1);
        err_inc      = wr_ok && (wr_err != '0);
        err_dec      = rd_ok && (mem_rdata[ERR_W-1:0] != '0);
        count_next   = count_reg + CW'(wr_ok) - CW'(rd_ok);
        err_cnt_next = err_cnt_reg + CW'(err_inc) - CW'(err_dec);
        if (flush_all) begin
            count_next   = '0;
            err_cnt_next = '0;
        end
    end

    // Pointers, occupancy and all status flags move together on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            err_cnt_reg    <= '0;
            empty_reg      <= 1'b1;
            full_reg       <= 1'b0;
            trig_reg       <= 1'b0;
            err_pend_reg   <= 1'b0;
            overrun_reg    <= 1'b0;
            fifo_en_reg    <= 1'b0;
            auto_flush_reg <= 1'b0;
        end else begin
            fifo_en_reg    <= fifo_en;
            auto_flush_reg <= (fifo_en != fifo_en_reg);
            if (flush_all) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg    <= count_next;
            err_cnt_reg  <= err_cnt_next;
            empty_reg    <= (count_next == '0);
            full_reg     <= (count_next >= eff_depth);
            trig_reg     <= (count_next >= thresh);
            err_pend_reg <= (err_cnt_next != '0);
            overrun_reg  <= flush_all ? 1'b0 : (overrun_reg || (wr_valid && !wr_ok));
        end
    end

    assign rd_data        = mem_rdata[WW-1:ERR_W];
    assign rd_err         = mem_rdata[ERR_W-1:0];
    assign empty          = empty_reg;
    assign fifo_full      = full_reg;
    assign count          = count_reg;
    assign trig_irq       = trig_reg;
    assign err_pending    = err_pend_reg;
    assign overrun_sticky = overrun_reg;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [19:0] idle_cnt_reg;
    logic        timeout_reg;

    // Idle timer: restarts on any traffic or flush, counts while data waits, freezes once fired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (flush_all || wr_ok || rd_ok) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (!timeout_reg && !empty_reg) begin
            idle_cnt_reg <= idle_cnt_reg + 20'd1;
            if (((idle_cnt_reg + 20'd1) == timeout_cycles) && (timeout_cycles != '0)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_irq = timeout_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign timeout_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        fifo_en;
    logic        flush;
    logic        wr_valid;
    logic [8:0]  wr_data;
    logic [2:0]  wr_err;
    logic        rd_en;
    logic [1:0]  trig_sel;
    logic [19:0] timeout_cycles;
    logic [8:0]  rd_data;
    logic [2:0]  rd_err;
    logic        empty;
    logic        fifo_full;
    logic [4:0]  count;
    logic        trig_irq;
    logic        err_pending;
    logic        overrun_sticky;
    logic        timeout_irq;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 0;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (9),
        .ERR_W  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_en        (fifo_en),
        .flush          (flush),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_err         (wr_err),
        .rd_en          (rd_en),
        .trig_sel       (trig_sel),
        .timeout_cycles (timeout_cycles),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .empty          (empty),
        .fifo_full      (fifo_full),
        .count          (count),
        .trig_irq       (trig_irq),
        .err_pending    (err_pending),
        .overrun_sticky (overrun_sticky),
        .timeout_irq    (timeout_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [11:0] m_q[$];
    logic        m_prev_en = 1'b0;
    logic        m_auto    = 1'b0;
    logic        m_ovr     = 1'b0;
    int          m_idle    = 0;
    logic        m_tirq    = 1'b0;
    logic [4:0]  exp_count = '0;
    logic        exp_empty = 1'b1;
    logic        exp_full  = 1'b0;
    logic        exp_trig  = 1'b0;
    logic        exp_errp  = 1'b0;
    logic        exp_ovr   = 1'b0;
    logic        exp_tirq  = 1'b0;

    always @(posedge clk) begin : model
        logic        fl, do_rd, do_wr, was_busy;
        logic [11:0] e;
        int          eff, thr, nerr;
        if (!rst_n) begin
            m_q.delete();
            m_prev_en = 1'b0;
            m_auto    = 1'b0;
            m_ovr     = 1'b0;
            m_idle    = 0;
            m_tirq    = 1'b0;
            exp_count = '0;
            exp_empty = 1'b1;
            exp_full  = 1'b0;
            exp_trig  = 1'b0;
            exp_errp  = 1'b0;
            exp_ovr   = 1'b0;
            exp_tirq  = 1'b0;
        end else begin
            fl        = flush || m_auto;
            m_auto    = (fifo_en != m_prev_en);
            m_prev_en = fifo_en;
            was_busy  = (m_q.size() != 0);
            do_rd     = 1'b0;
            do_wr     = 1'b0;
            if (fl) begin
                m_q.delete();
                m_ovr = 1'b0;
            end else begin
                do_rd = rd_en && was_busy;
                do_wr = wr_valid && (!exp_full || do_rd);
                if (wr_valid && !do_wr) begin
                    m_ovr = 1'b1;
                    $display("txn drop data=%03h err=%0d", wr_data, wr_err);
                end
                if (do_rd) begin
                    e = m_q.pop_front();
                    $display("txn read data=%03h err=%0d", e[11:3], e[2:0]);
                end
                if (do_wr) begin
                    m_q.push_back({wr_data, wr_err});
                    $display("txn write data=%03h err=%0d", wr_data, wr_err);
                end
            end
            eff = fifo_en ? DEPTH : 1;
            case (trig_sel)
                2'd0:    thr = 1;
                2'd1:    thr = DEPTH / 4;
                2'd2:    thr = DEPTH / 2;
                default: thr = DEPTH - 2;
            endcase
            if (!fifo_en) thr = 1;
            nerr = 0;
            foreach (m_q[i]) begin
                e = m_q[i];
                if (e[2:0] != 3'd0) nerr++;
            end
            exp_count = 5'(m_q.size());
            exp_empty = (m_q.size() == 0);
            exp_full  = (m_q.size() >= eff);
            exp_trig  = (m_q.size() >= thr);
            exp_errp  = (nerr != 0);
            exp_ovr   = m_ovr;
`ifdef UART_RX_FIFO_TIMEOUT_EN
            if (fl || do_rd || do_wr) begin
                m_idle = 0;
                m_tirq = 1'b0;
            end else if (!m_tirq && was_busy) begin
                m_idle++;
                if ((m_idle == int'(timeout_cycles)) && (timeout_cycles != 20'd0)) m_tirq = 1'b1;
            end
            exp_tirq = m_tirq;
`endif
        end
    end

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin : compare
        logic [11:0] head;
        if (cmp_on) begin
            chk("model_count", 32'(count), 32'(exp_count));
            chk("model_empty", 32'(empty), 32'(exp_empty));
            chk("model_full", 32'(fifo_full), 32'(exp_full));
            chk("model_trig", 32'(trig_irq), 32'(exp_trig));
            chk("model_errp", 32'(err_pending), 32'(exp_errp));
            chk("model_overrun", 32'(overrun_sticky), 32'(exp_ovr));
            chk("model_timeout", 32'(timeout_irq), 32'(exp_tirq));
            if (!exp_empty && m_q.size() != 0) begin
                head = m_q[0];
                chk("model_rd_data", 32'(rd_data), 32'(head[11:3]));
                chk("model_rd_err", 32'(rd_err), 32'(head[2:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d, input logic [2:0] e);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_err   = e;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    initial begin
        int wp, rp;
        rst_n = 1'b0; fifo_en = 1'b1; flush = 1'b0; wr_valid = 1'b0;
        wr_data = '0; wr_err = '0; rd_en = 1'b0; trig_sel = 2'd0; timeout_cycles = '0;
        @(posedge clk);
        cmp_on = 1'b1;
        repeat (2) cyc();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_overrun", 32'(overrun_sticky), 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();

        // Fill without reads, overflow, drain in order.
        for (int i = 0; i < 16; i++) push(9'(i), 3'd0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(fifo_full), 32'd1);
        push(9'h1FF, 3'd0);
        chk("fill_overrun", 32'(overrun_sticky), 32'd1);
        chk("fill_count_after_drop", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            pop();
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Simultaneous read+write when full and when empty.
        do_flush();
        for (int i = 0; i < 16; i++) push(9'(9'h20 + i), 3'd0);
        wr_valid = 1'b1; wr_data = 9'h0AB; wr_err = 3'd0; rd_en = 1'b1;
        cyc();
        wr_valid = 1'b0; rd_en = 1'b0;
        chk("full_rw_count", 32'(count), 32'd16);
        chk("full_rw_overrun", 32'(overrun_sticky), 32'd0);
        chk("full_rw_head", 32'(rd_data), 32'h21);
        do_flush();
        chk("flush_empty", 32'(empty), 32'd1);
        wr_valid = 1'b1; wr_data = 9'h033; rd_en = 1'b1;
        cyc();
        wr_valid = 1'b0; rd_en = 1'b0;
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_data", 32'(rd_data), 32'h033);

        // Single holding register mode.
        fifo_en = 1'b0;
        repeat (3) cyc();
        push(9'h155, 3'd0);
        chk("nofifo_full", 32'(fifo_full), 32'd1);
        push(9'h0AA, 3'd0);
        chk("nofifo_data", 32'(rd_data), 32'h155);
        chk("nofifo_overrun", 32'(overrun_sticky), 32'd1);
        chk("nofifo_count", 32'(count), 32'd1);

        // Error tracking and trigger level.
        fifo_en = 1'b1;
        repeat (3) cyc();
        trig_sel = 2'd1;
        push(9'h000, 3'b100);
        push(9'h001, 3'b000);
        push(9'h002, 3'b010);
        chk("err_pending_3", 32'(err_pending), 32'd1);
        chk("trig_3", 32'(trig_irq), 32'd0);
        push(9'h003, 3'b000);
        chk("trig_4", 32'(trig_irq), 32'd1);
        pop();
        pop();
        chk("err_pending_pop2", 32'(err_pending), 32'd1);
        pop();
        chk("err_pending_pop3", 32'(err_pending), 32'd0);
        pop();
        trig_sel = 2'd0;

        // Flush against a concurrent write, then mode-change flush.
        for (int i = 0; i < 17; i++) push(9'(i), 3'd1);
        chk("pre_flush_overrun", 32'(overrun_sticky), 32'd1);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 9'h111;
        cyc();
        flush = 1'b0; wr_valid = 1'b0;
        chk("flush_wr_count", 32'(count), 32'd0);
        chk("flush_wr_empty", 32'(empty), 32'd1);
        chk("flush_wr_overrun", 32'(overrun_sticky), 32'd0);
        for (int i = 0; i < 5; i++) push(9'(9'h40 + i), 3'd0);
        fifo_en = 1'b0;
        cyc();
        chk("mode_chg_1cyc", 32'(empty), 32'd0);
        cyc();
        chk("mode_chg_2cyc", 32'(empty), 32'd1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
        // Idle timeout fires exactly timeout_cycles after the last write.
        fifo_en = 1'b1;
        repeat (3) cyc();
        timeout_cycles = 20'd100;
        push(9'h077, 3'd0);
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (k == 99) chk("timeout_before", 32'(timeout_irq), 32'd0);
            if (k == 100) chk("timeout_at", 32'(timeout_irq), 32'd1);
        end
        pop();
        chk("timeout_cleared", 32'(timeout_irq), 32'd0);
`endif

        // Randomized traffic with busy, draining and idle phases.
        fifo_en = 1'b1;
        timeout_cycles = 20'd9;
        for (int c = 0; c < 2400; c++) begin
            case ((c / 200) % 3)
                0:       begin wp = 70; rp = 30; end
                1:       begin wp = 30; rp = 70; end
                default: begin wp = 5;  rp = 4;  end
            endcase
            flush    = ($urandom_range(79) == 0);
            if ($urandom_range(299) == 0) fifo_en = ~fifo_en;
            if ($urandom_range(99) == 0) trig_sel = 2'($urandom_range(3));
            wr_valid = ($urandom_range(99) < wp);
            wr_data  = 9'($urandom);
            wr_err   = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
            rd_en    = ($urandom_range(99) < rp);
            cyc();
        end
        wr_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
